// File: rtl/mavg_axis_packetizer.sv
// Packetizes moving-average filter samples onto an AXI-Stream master through a
// small FIFO and a registered output stage; tlast marks every packet_len-th beat.
module mavg_axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [15:0]                     packet_len,
    input  logic                            in_data_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [15:0]           beat_q, beat_d;
    logic [15:0]           len_q, len_d;
    logic                  overflow_q, overflow_d;

    logic        full, empty, wr_en, rd_en, xfer, drop;
    logic [15:0] beat_after, new_len, cur_len;

    always_comb begin
        full       = (count_q == CNT_FULL);
        empty      = (count_q == '0);
        wr_en      = in_data_valid & enable & ~full;
        drop       = in_data_valid & enable & full;
        xfer       = tvalid_q & m_axis_tready;
        rd_en      = ~empty & (~tvalid_q | m_axis_tready);
        // Beat index the next loaded sample will occupy, after this edge's transfer.
        beat_after = xfer ? (tlast_q ? 16'd0 : beat_q + 16'd1) : beat_q;
        new_len    = (packet_len == 16'd0) ? 16'd1 : packet_len;
        cur_len    = (beat_after == 16'd0) ? new_len : len_q;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        len_d      = len_q;
        beat_d     = beat_after;
        overflow_d = overflow_q | drop;

        if (wr_en) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            tdata_d  = mem_q[rd_ptr_q];
            tvalid_d = 1'b1;
            tlast_d  = (beat_after == cur_len - 16'd1);
            len_d    = cur_len;
        end else if (xfer) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            beat_q     <= 16'd0;
            len_q      <= 16'd1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign fifo_level    = count_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/mavg_axis_packetizer.md
MAVG_AXIS_PACKETIZER -- requirements
Module: mavg_axis_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the filter output sample and of m_axis_tdata.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: FIFO entries; power of two, minimum 4.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  1 = accept filter samples; 0 = ignore them.
REQ-006 SHALL have port packet_len  input  16  beats per packet; 0 is treated as 1.
REQ-007 SHALL have port in_data_valid  input  1  one-cycle strobe from moving_average_fir out_data_valid.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  sample from moving_average_fir out_data.
REQ-009 SHALL have port m_axis_tdata  output  DATA_WIDTH  AXI-Stream data.
REQ-010 SHALL have port m_axis_tvalid  output  1  AXI-Stream valid.
REQ-011 SHALL have port m_axis_tready  input  1  AXI-Stream ready.
REQ-012 SHALL have port m_axis_tlast  output  1  last beat of a packet.
REQ-013 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO entries in use, excluding the output register.
REQ-014 SHALL have port overflow  output  1  sticky flag: a sample was dropped.

Function
REQ-015 SHALL write in_data into the FIFO at the rising edge on which in_data_valid=1, enable=1 and the FIFO is not full.
REQ-016 SHALL drop the sample and set overflow to 1 if in_data_valid=1 and enable=1 while the FIFO is full; full is evaluated before any read in the same cycle.
REQ-017 SHALL ignore in_data_valid while enable=0, without setting overflow.
REQ-018 SHALL load the output register from the FIFO head on an edge where the FIFO is not empty and (m_axis_tvalid=0 or m_axis_tready=1).
REQ-019 SHALL deliver a sample written at edge E to m_axis_tvalid=1 after edge E+1 when the FIFO and output register are empty (latency 2 edges).
REQ-020 SHALL count a beat as transferred when m_axis_tvalid=1 and m_axis_tready=1 at a rising edge.
REQ-021 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 SHALL deassert m_axis_tvalid after a transfer when the FIFO is empty.
REQ-023 SHALL keep a 16-bit beat counter and a latched packet length; packet_len is latched when the first beat of a packet is loaded into the output register, with 0 mapped to 1.
REQ-024 SHALL assert m_axis_tlast on the beat whose counter equals latched_len-1, then clear the counter to 0 on that beat's transfer.
REQ-025 SHALL ignore packet_len changes mid-packet; the new value takes effect at the next packet's first beat.
REQ-026 SHALL leave the packet state unchanged when enable=0; draining continues, and a partial packet resumes when enable returns to 1.
REQ-027 SHALL preserve sample order; no sample is duplicated or reordered.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and update fifo_level by +1 on a write, -1 on a read, and 0 on simultaneous write and read.

Reset
REQ-029 SHALL, while rst=0 and at any time including mid-packet, immediately set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fifo_level=0, overflow=0, beat counter=0, latched length=1, and empty the FIFO.
REQ-030 SHALL start operating at the first rising clk edge after rst returns to 1; overflow clears only on reset.

Verification
REQ-031 SHALL cover: packet_len=4, tready=1, samples 0..7 one per 21 cycles -> 8 beats in order, tlast=1 only on data 3 and 7, overflow=0.
REQ-032 SHALL cover: FIFO_DEPTH=16, tready=0, samples 0..19 back-to-back -> output register holds 0, fifo_level=16, samples 17..19 dropped, overflow=1; after tready=1 -> beats 0..16 in order, then tvalid=0.
REQ-033 SHALL cover: packet_len=0, three samples -> every beat has tlast=1.
REQ-034 SHALL cover: packet_len=4, changed to 2 after beat 1 -> tlast on beat 3, next packet tlast every 2 beats.
REQ-035 SHALL cover: tready toggling every cycle during a 6-beat stream -> tdata and tlast stable while stalled, no loss, no duplicates.
REQ-036 SHALL cover: rst=0 asserted mid-packet with fifo_level=5 and overflow=1 -> all outputs 0 asynchronously; after release, the next packet starts at beat 0.
